// File: rtl/fft_spectrum_capture_if.sv
// AXI4-Stream channel carrying FFT output beats: {imag, real} in tdata, XK_INDEX in tuser.
interface fft_spectrum_capture_if #(
  parameter int DW = 16
) ();
  logic [2*DW-1:0] tdata;
  logic [15:0]     tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_spectrum_capture.sv
// FFT output sink: squares each bin into a power RAM, tracks the peak bin and
// checks frame length against tlast; the stored spectrum is read back via rd_*.
module fft_spectrum_capture #(
  parameter int FFT_N = 1024,
  parameter int IDX_W = 10,
  parameter int DW    = 16,
  parameter int PW    = 2*DW+1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  fft_spectrum_capture_if.slave s_axis,
  input  logic                 arm,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_tlast_early,
  output logic                 err_tlast_missing,
  output logic [IDX_W-1:0]     peak_bin,
  output logic [PW-1:0]        peak_pwr,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [PW-1:0]        rd_data,
  output logic                 rd_valid
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t                 state;
  logic                   tready_q;
  logic [IDX_W-1:0]       beat_cnt;

  logic                   s1_v;
  logic signed [DW-1:0]   s1_re;
  logic signed [DW-1:0]   s1_im;
  logic [IDX_W-1:0]       s1_idx;

  logic                   s2_v;
  logic signed [2*DW-1:0] s2_re2;
  logic signed [2*DW-1:0] s2_im2;
  logic [IDX_W-1:0]       s2_idx;

  logic [PW-1:0]          s3_pwr;
  logic [PW-1:0]          mem [FFT_N];

  logic accept;
  logic cap_beat;
  logic last_cnt;
  logic unused_tuser;

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid & tready_q;
  assign cap_beat      = accept && (state == CAPTURE);
  assign last_cnt      = (beat_cnt == IDX_W'(FFT_N-1));
  assign unused_tuser  = ^s_axis.tuser[15:IDX_W];

  // Squares are non-negative, so their bit patterns zero-extend safely; the
  // worst case (-2^(DW-1))^2 * 2 = 2^(2*DW-1) still fits without wrapping.
  assign s3_pwr = PW'(unsigned'(s2_re2)) + PW'(unsigned'(s2_im2));

  // Stage 1: register the raw beat. Only beats of an armed frame enter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_idx <= '0;
    end else begin
      s1_v <= cap_beat;
      if (cap_beat) begin
        s1_re  <= s_axis.tdata[DW-1:0];
        s1_im  <= s_axis.tdata[2*DW-1:DW];
        s1_idx <= s_axis.tuser[IDX_W-1:0];
      end
    end
  end

  // Stage 2: signed squares.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_re2 <= '0;
      s2_im2 <= '0;
      s2_idx <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_re2 <= s1_re * s1_re;
        s2_im2 <= s1_im * s1_im;
        s2_idx <= s1_idx;
      end
    end
  end

  // Stage 3: write the summed power into the spectrum RAM.
  // NOTE: the RAM has no reset; contents persist across reset so it maps to block memory.
  always_ff @(posedge sys_clk) begin
    if (s2_v) mem[s2_idx] <= s3_pwr;
  end

  // Read port: same-cycle write to the same address returns the old word.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  // Control FSM with registered outputs; the peak tracker lives here so the
  // clear on arm and the stage-3 update share one priority order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      tready_q          <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      beat_cnt          <= '0;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
      peak_bin          <= '0;
      peak_pwr          <= '0;
    end else begin
      frame_done <= 1'b0;

      // Strict compare: on a tie the earlier-received bin is kept.
      if (s2_v && (s3_pwr > peak_pwr)) begin
        peak_pwr <= s3_pwr;
        peak_bin <= s2_idx;
      end

      case (state)
        IDLE: begin
          tready_q <= 1'b1;
          if (arm) begin
            state             <= CAPTURE;
            busy              <= 1'b1;
            beat_cnt          <= '0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
            peak_bin          <= '0;
            peak_pwr          <= '0;
          end
        end

        CAPTURE: begin
          if (accept) begin
            beat_cnt <= beat_cnt + IDX_W'(1);
            if (s_axis.tlast || last_cnt) begin
              state    <= FLUSH;
              tready_q <= 1'b0;
              if (s_axis.tlast && !last_cnt) err_tlast_early   <= 1'b1;
              if (!s_axis.tlast && last_cnt) err_tlast_missing <= 1'b1;
            end
          end
        end

        FLUSH: begin
          // Once stage 1 is empty the final write happens on this edge.
          if (!s1_v) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            tready_q   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Directed bench for fft_spectrum_capture: frame-level model of RAM, peak and
// framing errors, checked by a per-cycle monitor plus hand-computed literals.
`timescale 1ns/1ps
module tb_fft_spectrum_capture;
  localparam int FFT_N = 1024;
  localparam int IDX_W = 10;
  localparam int DW    = 16;
  localparam int PW    = 33;

  logic             sys_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic             arm     = 1'b0;
  logic             rd_en   = 1'b0;
  logic [IDX_W-1:0] rd_addr = '0;
  logic             busy, frame_done, err_tlast_early, err_tlast_missing, rd_valid;
  logic [IDX_W-1:0] peak_bin;
  logic [PW-1:0]    peak_pwr, rd_data;

  fft_spectrum_capture_if #(.DW(DW)) s_if ();

  fft_spectrum_capture #(.FFT_N(FFT_N), .IDX_W(IDX_W), .DW(DW), .PW(PW)) dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .s_axis            (s_if),
    .arm               (arm),
    .busy              (busy),
    .frame_done        (frame_done),
    .err_tlast_early   (err_tlast_early),
    .err_tlast_missing (err_tlast_missing),
    .peak_bin          (peak_bin),
    .peak_pwr          (peak_pwr),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame description and model state
  logic signed [15:0] fr_re [FFT_N];
  logic signed [15:0] fr_im [FFT_N];
  int                 fr_idx[FFT_N];
  bit                 fr_last[FFT_N];
  int                 fr_n;

  longint exp_ram[FFT_N];
  int     exp_peak_bin;
  longint exp_peak_pwr;
  bit     exp_early, exp_missing;

  function automatic void new_frame(input bit reverse);
    for (int i = 0; i < FFT_N; i++) begin
      fr_re[i]   = '0;
      fr_im[i]   = '0;
      fr_idx[i]  = reverse ? (FFT_N-1-i) : i;
      fr_last[i] = (i == FFT_N-1);
    end
    fr_n = FFT_N;
  endfunction

  function automatic void set_bin(input int bin, input int re, input int im);
    for (int i = 0; i < FFT_N; i++)
      if (fr_idx[i] == bin) begin
        fr_re[i] = 16'(re);
        fr_im[i] = 16'(im);
      end
  endfunction

  // Frame ends at the first tlast or the FFT_N-th beat; later beats of the same
  // bin overwrite; peak is the first bin reaching the maximum power.
  function automatic void model_frame();
    longint pk;
    int     pb;
    longint p;
    pk = 0; pb = 0; exp_early = 0; exp_missing = 0;
    for (int i = 0; i < fr_n; i++) begin
      p = longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
      exp_ram[fr_idx[i]] = p;
      if (p > pk) begin
        pk = p;
        pb = fr_idx[i];
      end
      if (fr_last[i] || i == FFT_N-1) begin
        exp_early   = fr_last[i] && (i < FFT_N-1);
        exp_missing = !fr_last[i] && (i == FFT_N-1);
        break;
      end
    end
    exp_peak_bin = pb;
    exp_peak_pwr = pk;
  endfunction

  // Monitor: read port, idle tready, and frame_done contents/latency.
  int     cyc = 0, last_beat_cyc = 0, done_cnt = 0;
  bit     done_expected = 0, rd_pend = 0, ready_chk = 0;
  longint rd_exp = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (!rst_n) begin
      rd_pend = 0;
    end else begin
      check("rd_valid", rd_valid, rd_pend);
      if (rd_valid && rd_pend) check("rd_data", rd_data, rd_exp);
      rd_pend = rd_en;
      rd_exp  = exp_ram[rd_addr];
      if (ready_chk && !busy) check("tready_idle", s_if.tready, 1);
      if (s_if.tvalid && s_if.tready && busy) last_beat_cyc = cyc;
      if (frame_done) begin
        check("frame_done_expected", done_expected, 1);
        check("done_latency", cyc - last_beat_cyc, 3);
        check("busy_at_done", busy, 0);
        check("peak_bin", peak_bin, exp_peak_bin);
        check("peak_pwr", peak_pwr, exp_peak_pwr);
        check("err_tlast_early", err_tlast_early, exp_early);
        check("err_tlast_missing", err_tlast_missing, exp_missing);
        done_cnt++;
        done_expected = 0;
      end
    end
  end

  // Drivers: every task starts and ends 1 ns after a rising edge.
  task automatic drive_beat(input int i);
    int waited;
    waited = 0;
    s_if.tdata  = {fr_im[i], fr_re[i]};
    s_if.tuser  = 16'(fr_idx[i]) | 16'hFC00;
    s_if.tlast  = fr_last[i];
    s_if.tvalid = 1'b1;
    @(negedge sys_clk);
    while (!s_if.tready && waited < 50) begin
      @(negedge sys_clk);
      waited++;
    end
    if (!s_if.tready) check("tready_wait_timeout", 0, 1);
    @(posedge sys_clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_beats(input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge sys_clk); #1;
      end
      drive_beat(i);
    end
  endtask

  task automatic pulse_arm(input bit with_junk);
    if (with_junk) begin
      s_if.tdata  = {16'sd0, 16'sd1000};
      s_if.tuser  = 16'd100;
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b1;
    end
    arm = 1'b1;
    @(posedge sys_clk); #1;
    arm = 1'b0;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int t;
    t = 0;
    while (done_cnt == start && t < 40) begin
      @(posedge sys_clk);
      t++;
    end
    #1;
    check("frame_done_seen", done_cnt - start, 1);
    repeat (4) @(posedge sys_clk);
    #1;
    check("frame_done_once", done_cnt - start, 1);
  endtask

  task automatic run_frame(input int gap_max, input bit junk);
    int start;
    model_frame();
    done_expected = 1;
    start = done_cnt;
    pulse_arm(junk);
    send_beats(0, fr_n - 1, gap_max);
    wait_done(start);
  endtask

  task automatic read_bins();
    int addrs[12] = '{0, 5, 12, 36, 37, 100, 199, 511, 512, 777, 900, 1023};
    foreach (addrs[k]) begin
      rd_en   = 1'b1;
      rd_addr = IDX_W'(addrs[k]);
      @(posedge sys_clk); #1;
    end
    rd_en = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic rd_lit(input int addr, input longint exp);
    rd_en   = 1'b1;
    rd_addr = IDX_W'(addr);
    @(posedge sys_clk); #1;
    rd_en = 1'b0;
    @(negedge sys_clk);
    check("rd_literal", rd_data, exp);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int start;
    s_if.tdata = '0; s_if.tuser = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    foreach (exp_ram[i]) exp_ram[i] = 0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tready", s_if.tready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_peak_pwr", peak_pwr, 0);
    check("rst_rd_valid", rd_valid, 0);
    @(negedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    ready_chk = 1;

    // Natural order, single tone at bin 37; arm coincides with a junk beat
    new_frame(0);
    set_bin(37, 300, -400);
    run_frame(0, 1);
    check("lit_peak_bin_37", peak_bin, 37);
    check("lit_peak_pwr_250000", peak_pwr, 250000);
    rd_lit(37, 250000);
    rd_lit(36, 0);
    read_bins();

    // Same frame with random tvalid gaps
    run_frame(5, 0);
    check("gap_peak_pwr", peak_pwr, 250000);
    check("gap_no_early", err_tlast_early, 0);
    read_bins();

    // Early tlast on beat 511
    new_frame(0);
    set_bin(37, 300, -400);
    fr_last[511]  = 1;
    fr_last[1023] = 0;
    fr_n = 512;
    run_frame(0, 0);
    check("lit_err_early", err_tlast_early, 1);
    check("lit_busy_after_early", busy, 0);
    read_bins();

    // Beat 1023 without tlast
    new_frame(0);
    fr_last[1023] = 0;
    set_bin(600, 7, 7);
    run_frame(0, 0);
    check("lit_err_missing", err_tlast_missing, 1);
    check("lit_early_cleared", err_tlast_early, 0);

    // Tie: bins 5 and 900 both 1000, bin 5 sent first
    new_frame(0);
    set_bin(5, 30, 10);
    set_bin(900, -10, 30);
    run_frame(0, 0);
    check("lit_tie_bin_5", peak_bin, 5);
    check("lit_tie_pwr", peak_pwr, 1000);
    read_bins();

    // Full-scale corner, bins sent in reverse order
    new_frame(1);
    set_bin(12, -32768, -32768);
    set_bin(900, 3, 4);
    run_frame(1, 0);
    check("lit_peak_bin_12", peak_bin, 12);
    rd_lit(12, 64'd2147483648);
    read_bins();

    // Beats while idle are discarded
    new_frame(0);
    set_bin(12, 0, 0);
    set_bin(37, 1, 1);
    start = done_cnt;
    send_beats(0, 40, 1);
    repeat (6) @(posedge sys_clk);
    #1;
    check("idle_no_done", done_cnt - start, 0);
    check("idle_busy", busy, 0);
    rd_lit(12, 64'd2147483648);
    rd_lit(37, 0);

    // arm mid-frame is ignored
    new_frame(0);
    set_bin(37, 300, -400);
    set_bin(700, -20, 0);
    model_frame();
    done_expected = 1;
    start = done_cnt;
    pulse_arm(0);
    send_beats(0, 499, 0);
    pulse_arm(0);
    send_beats(500, 1023, 0);
    wait_done(start);
    check("armbusy_no_early", err_tlast_early, 0);
    read_bins();
    rd_lit(37, 250000);

    // Reset at beat 200
    new_frame(0);
    set_bin(37, 300, -400);
    pulse_arm(0);
    send_beats(0, 199, 0);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_peak", peak_pwr, 250000);
    ready_chk = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_tready", s_if.tready, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_err_early", err_tlast_early, 0);
    check("arst_err_missing", err_tlast_missing, 0);
    check("arst_peak_bin", peak_bin, 0);
    check("arst_peak_pwr", peak_pwr, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_rd_valid", rd_valid, 0);
    @(negedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    ready_chk = 1;

    // Clean capture after the aborted frame
    new_frame(0);
    set_bin(37, 300, -400);
    set_bin(777, -1000, 2000);
    run_frame(0, 0);
    check("lit_post_rst_bin", peak_bin, 777);
    check("lit_post_rst_pwr", peak_pwr, 5000000);
    check("post_rst_no_missing", err_tlast_missing, 0);
    read_bins();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
